gated_clock_divider: RTL and testbench

- Generates a gated, divided clock from the single source clock.
- Exports the standard gated-clock triple: CLK_OUT, CLK_GATE_OUT and PREEDGE.
- Producer end of the gated-clock interface consumed by inverter/mux/crossing blocks.
- Gate requests are deferred to a safe point in the low phase, so the output clock never produces a runt pulse.

---
 rtl/gated_clk_pkg.sv | 14 +
 rtl/gcd_phase_counter.sv | 40 ++++
 rtl/gated_clock_divider.sv | 125 ++++++++++++
 tb/tb_gated_clock_divider.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gated_clk_pkg.sv
// Shared types, constants and helpers for the gated clock divider.
package gated_clk_pkg;

  localparam int unsigned DEFAULT_CNT_W = 8;
  localparam logic DEFAULT_INIT_GATE = 1'b1;

  typedef logic [DEFAULT_CNT_W-1:0] phase_cnt_t;

  // Period in source cycles; evaluated at 32 bits so low+high never overflows.
  function automatic int unsigned calc_period(int unsigned low, int unsigned high);
    return low + high;
  endfunction

endpackage

// File: rtl/gcd_phase_counter.sv
// Phase counter for the gated clock divider: wrap detection, next count and
// the pre-edge phase compare.
module gcd_phase_counter
  import gated_clk_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] next_cnt,
  output logic             wrap,
  output logic             preedge_raw
);

  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    // The all-ones guard keeps the counter from rolling over if a runtime
    // period ever exceeds the counter range.
    wrap = (32'(cnt_q) == calc_period(32'(low_cycles), 32'(high_cycles)) - 32'd1) ||
           (cnt_q == '1);
    preedge_raw = (cnt_q == low_cycles - CNT_W'(1));
    next_cnt = cnt_q;
    if (advance) begin
      next_cnt = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= next_cnt;
    end
  end

endmodule

// File: rtl/gated_clock_divider.sv
// Gated, divided clock producer (CLK_OUT / CLK_GATE_OUT / PREEDGE).
// Optional runtime divisor: define GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN.
module gated_clock_divider
  import gated_clk_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned LOW_CYCLES  = 1,
  parameter int unsigned HIGH_CYCLES = 1,
  parameter logic        INIT_GATE   = DEFAULT_INIT_GATE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_GATE_IN,
  input  logic             SET_GATE_EN,
  input  logic             SET_GATE_VAL,
`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
  input  logic             DIV_LD,
  input  logic [CNT_W-1:0] DIV_LOW,
  input  logic [CNT_W-1:0] DIV_HIGH,
`endif
  output logic             CLK_OUT,
  output logic             CLK_GATE_OUT,
  output logic             PREEDGE,
  output logic             GATE_PENDING
);

  localparam logic [CNT_W-1:0] LOW_INIT  = CNT_W'(LOW_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_INIT = CNT_W'(HIGH_CYCLES);

  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             wrap;
  logic             preedge_raw;
  logic             apply;

  assign apply = CLK_GATE_IN & wrap;

`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
  logic [CNT_W-1:0] low_q, high_q, low_sh_q, high_sh_q;

  function automatic logic [CNT_W-1:0] clamp_one(logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Active counts change only at the wrap so a period in flight is never altered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      low_q     <= LOW_INIT;
      high_q    <= HIGH_INIT;
      low_sh_q  <= LOW_INIT;
      high_sh_q <= HIGH_INIT;
    end else begin
      if (DIV_LD) begin
        low_sh_q  <= clamp_one(DIV_LOW);
        high_sh_q <= clamp_one(DIV_HIGH);
      end
      if (apply) begin
        low_q  <= low_sh_q;
        high_q <= high_sh_q;
      end
    end
  end

  assign low_cnt  = low_q;
  assign high_cnt = high_q;
`else
  assign low_cnt  = LOW_INIT;
  assign high_cnt = HIGH_INIT;
`endif

  gcd_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk        (CLK),
    .rst        (RST),
    .advance    (CLK_GATE_IN),
    .low_cycles (low_cnt),
    .high_cycles(high_cnt),
    .next_cnt   (next_cnt),
    .wrap       (wrap),
    .preedge_raw(preedge_raw)
  );

  logic clk_out_q, clk_out_d;
  logic gate_q, next_gate;
  logic pend_val_q;
  logic pending_q;

  always_comb begin
    next_gate = gate_q;
    if (apply) begin
      next_gate = SET_GATE_EN ? SET_GATE_VAL : pend_val_q;
    end
    clk_out_d = clk_out_q;
    if (CLK_GATE_IN) begin
      clk_out_d = (next_cnt >= low_cnt) & next_gate;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_out_q  <= 1'b0;
      gate_q     <= INIT_GATE;
      pend_val_q <= INIT_GATE;
      pending_q  <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
      gate_q    <= next_gate;
      if (apply) begin
        pend_val_q <= next_gate;
        pending_q  <= 1'b0;
      end else if (SET_GATE_EN) begin
        pend_val_q <= SET_GATE_VAL;
        pending_q  <= (SET_GATE_VAL != gate_q);
      end
    end
  end

  assign CLK_OUT      = clk_out_q;
  assign CLK_GATE_OUT = gate_q;
  assign GATE_PENDING = pending_q;
  assign PREEDGE      = ~RST & CLK_GATE_IN & next_gate & preedge_raw;

endmodule

// File: tb/tb_gated_clock_divider.sv
// Bench for gated_clock_divider: two instances (L1/H1 and L3/H2) checked every
// cycle against a period-position model.
module tb_gated_clock_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cgi = 1'b1;
  logic       set_en = 1'b0;
  logic       set_val = 1'b0;
  logic       div_ld = 1'b0;
  logic [7:0] div_low = 8'd1;
  logic [7:0] div_high = 8'd1;

  logic a_clk, a_gate, a_pre, a_pend;
  logic b_clk, b_gate, b_pre, b_pend;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gated_clock_divider #(
    .CNT_W(8), .LOW_CYCLES(1), .HIGH_CYCLES(1), .INIT_GATE(1'b1)
  ) dut_a (
    .CLK(clk), .RST(rst), .CLK_GATE_IN(cgi), .SET_GATE_EN(set_en), .SET_GATE_VAL(set_val),
`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
    .DIV_LD(div_ld), .DIV_LOW(div_low), .DIV_HIGH(div_high),
`endif
    .CLK_OUT(a_clk), .CLK_GATE_OUT(a_gate), .PREEDGE(a_pre), .GATE_PENDING(a_pend)
  );

  gated_clock_divider #(
    .CNT_W(8), .LOW_CYCLES(3), .HIGH_CYCLES(2), .INIT_GATE(1'b1)
  ) dut_b (
    .CLK(clk), .RST(rst), .CLK_GATE_IN(cgi), .SET_GATE_EN(set_en), .SET_GATE_VAL(set_val),
`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
    .DIV_LD(div_ld), .DIV_LOW(div_low), .DIV_HIGH(div_high),
`endif
    .CLK_OUT(b_clk), .CLK_GATE_OUT(b_gate), .PREEDGE(b_pre), .GATE_PENDING(b_pend)
  );

  // Model: position within the period, applied gate, last requested gate,
  // request-outstanding flag, active and shadow low/high counts.
  int m_pos[2];
  bit m_gate[2];
  bit m_req[2];
  bit m_pend[2];
  int m_L[2], m_H[2], m_sL[2], m_sH[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d]  = 0;
      m_gate[d] = 1'b1;
      m_req[d]  = 1'b1;
      m_pend[d] = 1'b0;
      m_L[d]    = (d == 0) ? 1 : 3;
      m_H[d]    = (d == 0) ? 1 : 2;
      m_sL[d]   = m_L[d];
      m_sH[d]   = m_H[d];
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (set_en) begin
        m_req[d]  = set_val;
        m_pend[d] = (set_val != m_gate[d]);
      end
      if (cgi) begin
        if (m_pos[d] == m_L[d] + m_H[d] - 1) begin
          m_gate[d] = m_req[d];
          m_pend[d] = 1'b0;
          m_pos[d]  = 0;
          m_L[d]    = m_sL[d];
          m_H[d]    = m_sH[d];
        end else begin
          m_pos[d]++;
        end
      end
      if (div_ld) begin
        m_sL[d] = (div_low == 8'd0) ? 1 : int'(div_low);
        m_sH[d] = (div_high == 8'd0) ? 1 : int'(div_high);
      end
    end
  endtask

  function automatic logic [7:0] expected();
    logic [7:0] v;
    v = '0;
    for (int d = 0; d < 2; d++) begin
      v[7-4*d -: 4] = {m_gate[d] && (m_pos[d] >= m_L[d]),
                       m_gate[d],
                       !rst && cgi && m_gate[d] && (m_pos[d] == m_L[d] - 1),
                       m_pend[d]};
    end
    return v;
  endfunction

  function automatic logic [7:0] observed();
    return {a_clk, a_gate, a_pre, a_pend, b_clk, b_gate, b_pre, b_pend};
  endfunction

  // Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic settle();
    @(negedge clk);
    if (rst) model_reset();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cgi = 1'b1; set_en = 1'b0;
    settle();
    checks++;
    if (observed() !== expected()) begin
      $display("FAIL reset_state got=%b want=%b", observed(), expected());
    end else passes++;
    checks++;
    if ({b_clk, b_gate, b_pre, b_pend} !== 4'b0100) begin
      $display("FAIL reset_literal got=%b want=0100", {b_clk, b_gate, b_pre, b_pend});
    end else passes++;
    clock_edge();
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 20; i++) begin
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL free_run cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 10 && m_pos[1] != 3; i++) clock_edge();
    checks++;
    if (m_pos[1] != 3 || b_clk !== 1'b1) begin
      $display("FAIL freeze_setup pos=%0d clk=%b want pos=3 clk=1", m_pos[1], b_clk);
    end else passes++;
    cgi = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) cgi = 1'b1;
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL freeze cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
    end
  endtask

  task automatic test_gate_off();
    for (int i = 0; i < 10 && m_pos[1] != 3; i++) clock_edge();
    set_en = 1'b1; set_val = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) begin
        set_en = 1'b1; set_val = 1'b1;
      end
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL gate_off cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
      set_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10 && m_pos[1] != 4; i++) clock_edge();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
      rst = 1'b0;
    end
  endtask

`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
  task automatic test_runtime_div();
    for (int i = 0; i < 10 && m_pos[1] != 1; i++) clock_edge();
    div_ld = 1'b1; div_low = 8'd5; div_high = 8'd5;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) begin
        div_ld = 1'b1; div_low = 8'd0; div_high = 8'd2;
      end
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL runtime_div cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
      div_ld = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      settle();
      checks++;
      if (observed() !== expected()) begin
        $display("FAIL random cyc=%0d got=%b want=%b", i, observed(), expected());
      end else passes++;
      clock_edge();
      rst      = ($urandom_range(0, 60) == 0);
      cgi      = ($urandom_range(0, 9) != 0);
      set_en   = cgi && ($urandom_range(0, 5) == 0);
      set_val  = 1'($urandom_range(0, 1));
`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
      div_ld   = ($urandom_range(0, 15) == 0);
      div_low  = 8'($urandom_range(0, 6));
      div_high = 8'($urandom_range(0, 6));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_free_run();
    test_freeze();
    test_gate_off();
    test_reset_mid();
`ifdef GATED_CLOCK_DIVIDER_RUNTIME_DIV_EN
    test_runtime_div();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
